// File: rtl/hdb3_dec.sv
`default_nettype none
// ============================================================================
// Module      : hdb3_dec
// Description : HDB3 dual-rail line decoder to NRZ. Removes 000V/B00V
//               substitutions, flags code errors, and reports loss of signal.
// Revision    : 1.0 - initial release
// ============================================================================
module hdb3_dec #(
    parameter int LOS_LEN = 16,
    parameter int ERR_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hdb3_p,
    input  logic             hdb3_n,
    output logic             nrz_out,
    output logic             out_valid,
    output logic             code_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             los
);

    localparam int                  c_ZRUN_W   = $clog2(LOS_LEN + 1);
    localparam logic [c_ZRUN_W-1:0] c_ZRUN_MAX = c_ZRUN_W'(LOS_LEN);
    localparam logic [c_ZRUN_W-1:0] c_ZRUN_3   = c_ZRUN_W'(3);

    logic [3:0]          r_d;
    logic                r_last_pol;
    logic                r_have_pol;
    logic [c_ZRUN_W-1:0] r_zrun;
    logic [2:0]          r_fill;
    logic                r_code_err;
    logic [ERR_W-1:0]    r_err_cnt;

    logic                w_mark;
    logic                w_illegal;
    logic                w_viol;
    logic                w_zero_hit;
    logic                w_err;
    logic                w_los_rise;
    logic [c_ZRUN_W-1:0] w_zrun_nxt;

    assign w_mark    = hdb3_p ^ hdb3_n;
    assign w_illegal = hdb3_p & hdb3_n;
    assign w_viol    = w_mark & r_have_pol & (hdb3_p == r_last_pol);

    always_comb begin
        w_zrun_nxt = r_zrun;
        if (w_mark) begin
            w_zrun_nxt = '0;
        end else if (r_zrun != c_ZRUN_MAX) begin
            w_zrun_nxt = r_zrun + 1'b1;
        end
    end

    // Fourth empty symbol in a row on a live line can never occur in HDB3.
    assign w_zero_hit = ~w_mark & r_have_pol & ~los & (r_zrun == c_ZRUN_3);
    assign w_err      = w_illegal | (w_viol & (r_d[0] | r_d[1])) | w_zero_hit;
    assign w_los_rise = ~los & (w_zrun_nxt == c_ZRUN_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d        <= '0;
            r_last_pol <= 1'b0;
            r_have_pol <= 1'b0;
            r_zrun     <= '0;
            r_fill     <= '0;
            r_code_err <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            // A violation wipes the window: the B three symbols back and the V.
            if (w_viol) begin
                r_d <= '0;
            end else begin
                r_d <= {r_d[2:0], w_mark};
            end

            if (w_los_rise) begin
                r_have_pol <= 1'b0;
            end else if (w_mark && !w_viol) begin
                r_have_pol <= 1'b1;
                r_last_pol <= hdb3_p;
            end

            r_zrun     <= w_zrun_nxt;
            r_code_err <= w_err;

            if (r_fill != 3'd4) begin
                r_fill <= r_fill + 3'd1;
            end

            if (w_err && (r_err_cnt != {ERR_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign nrz_out   = r_d[3];
    assign out_valid = (r_fill == 3'd4);
    assign code_err  = r_code_err;
    assign err_cnt   = r_err_cnt;
    assign los       = (r_zrun == c_ZRUN_MAX);

endmodule
`default_nettype wire
